// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Brief    : UART receive sequencer: pin sync, start detect, mid-bit strobe,
//            stop check and FWFT receive FIFO with sticky error flags.
// Revision : 1.0
// ============================================================================
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_pin,
    output logic       o_srx,
    output logic       o_signal,
    input  logic       i_Rx_valid,
    input  logic [7:0] i_Rx_data,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_overrun,
    input  logic       i_clr_err
);
    localparam int C_CW = $clog2(CLKS_PER_BIT);
    localparam int C_AW = $clog2(FIFO_DEPTH);
    localparam logic [C_CW-1:0] C_HALF_LOAD = C_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [C_CW-1:0] C_BIT_LOAD  = C_CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HALF = 2'd1,
        S_DATA = 2'd2,
        S_STOP = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_sync1, r_srx, r_srx_d;
    logic [C_CW-1:0]   r_baud_cnt, w_baud_nxt;
    logic [2:0]        r_bit_cnt, w_bit_nxt;
    logic              r_hold_vld;
    logic [7:0]        r_hold_data;
    logic [C_AW:0]     r_wr_ptr, r_rd_ptr;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic              r_frame_err, r_overrun;

    logic w_fall, w_tick, w_strobe, w_push_req, w_frame_bad, w_hold_clr;
    logic w_empty, w_full, w_pop, w_push, w_drop;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_srx   <= 1'b1;
            r_srx_d <= 1'b1;
        end else begin
            r_sync1 <= i_rx_pin;
            r_srx   <= r_sync1;
            r_srx_d <= r_srx;
        end
    end

    assign w_fall = ~r_srx & r_srx_d;
    assign w_tick = (r_baud_cnt == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_strobe    = 1'b0;
        w_push_req  = 1'b0;
        w_frame_bad = 1'b0;
        w_hold_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_baud_nxt  = C_HALF_LOAD;
                    w_state_nxt = S_HALF;
                end
            end
            S_HALF: begin
                if (w_tick) begin
                    w_strobe = 1'b1;
                    // Line back high at mid start bit: treat as a glitch.
                    if (r_srx) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_baud_nxt  = C_BIT_LOAD;
                        w_bit_nxt   = '0;
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt - 1'b1;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_strobe   = 1'b1;
                    w_baud_nxt = C_BIT_LOAD;
                    w_bit_nxt  = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt - 1'b1;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_strobe    = 1'b1;
                    w_hold_clr  = 1'b1;
                    w_state_nxt = S_IDLE;
                    if (r_srx) begin
                        w_push_req = r_hold_vld;
                    end else begin
                        w_frame_bad = 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The datapath clears its byte while waiting for the stop bit, so keep a copy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
        end else if (w_hold_clr) begin
            r_hold_vld  <= 1'b0;
        end else if (i_Rx_valid) begin
            r_hold_vld  <= 1'b1;
            r_hold_data <= i_Rx_data;
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                     (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
    assign w_pop   = ~w_empty & i_ready;
    assign w_push  = w_push_req & (~w_full | w_pop);
    assign w_drop  = w_push_req & w_full & ~w_pop;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[C_AW-1:0]] <= r_hold_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            // A set event outranks a clear in the same cycle.
            if (w_frame_bad)    r_frame_err <= 1'b1;
            else if (i_clr_err) r_frame_err <= 1'b0;
            if (w_drop)         r_overrun   <= 1'b1;
            else if (i_clr_err) r_overrun   <= 1'b0;
        end
    end

    assign o_srx       = r_srx;
    assign o_signal    = w_strobe;
    assign o_busy      = (r_state != S_IDLE);
    assign o_data      = r_mem[r_rd_ptr[C_AW-1:0]];
    assign o_valid     = ~w_empty;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Brief    : Scoreboard bench for uart_rx_ctrl with a behavioural Uart_Rx.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_ctrl;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_pin = 1'b1;
    logic       srx, sig, valid, busy, ferr, ovr;
    logic       rx_valid;
    logic [7:0] rx_data, data;
    logic       ready = 1'b0;
    logic       clr = 1'b0;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_pin(rx_pin), .o_srx(srx), .o_signal(sig),
        .i_Rx_valid(rx_valid), .i_Rx_data(rx_data), .o_data(data), .o_valid(valid),
        .i_ready(ready), .o_busy(busy), .o_frame_err(ferr), .o_overrun(ovr),
        .i_clr_err(clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural receive datapath: samples the synchronized line on each strobe.
    logic [1:0] ust;
    logic [2:0] ucnt;
    logic [7:0] ubyte;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ust <= 2'd0; ucnt <= 3'd0; ubyte <= 8'd0;
            rx_valid <= 1'b0; rx_data <= 8'd0;
        end else begin
            rx_valid <= 1'b0;
            rx_data  <= 8'd0;
            if (sig) begin
                case (ust)
                    2'd0: if (!srx) begin ust <= 2'd1; ucnt <= 3'd0; end
                    2'd1: begin
                        ubyte[ucnt] <= srx;
                        ucnt <= ucnt + 3'd1;
                        if (ucnt == 3'd7) begin
                            ust <= 2'd2;
                            rx_valid <= 1'b1;
                            rx_data <= {srx, ubyte[6:0]};
                        end
                    end
                    default: ust <= 2'd0;
                endcase
            end
        end
    end

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    logic exp_ferr = 1'b0;
    logic exp_ovr = 1'b0;
    int strobes[$];
    int vrise[$];
    int rxv_cnt = 0;
    logic prev_valid = 1'b0;
    logic [7:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted FIFO read.
    always @(negedge clk) begin
        if (sig) strobes.push_back(cyc);
        if (rx_valid) rxv_cnt++;
        if (valid && !prev_valid) vrise.push_back(cyc);
        prev_valid = valid;
        if (!rst && valid && ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop: got byte %0h expected no byte", data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pop data", {24'd0, data}, {24'd0, mon_exp});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives start, nbits data bits and (if complete) the stop bit.
    task automatic send(input logic [7:0] b, input logic stop, input int nbits,
                        input logic rdy_stop, output int p);
        p = cyc;
        rx_pin = 1'b0;
        tick(CPB);
        for (int i = 0; i < nbits; i++) begin
            rx_pin = b[i];
            tick(CPB);
        end
        if (nbits < 8) begin
            rx_pin = 1'b1;
        end else begin
            rx_pin = stop;
            tick(10);
            if (rdy_stop) ready = 1'b1;
            tick(CPB - 10);
            rx_pin = 1'b1;
        end
    endtask

    // Reference model: a good byte lands unless the FIFO is full with no pop.
    task automatic frame(input logic [7:0] b, input logic stop, input logic rdy_stop,
                         output int p);
        if (!stop) exp_ferr = 1'b1;
        else if (exp_q.size() < DEPTH || rdy_stop) exp_q.push_back(b);
        else exp_ovr = 1'b1;
        send(b, stop, 8, rdy_stop, p);
    endtask

    task automatic clear_err();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p, n0, wait_cnt;
        logic [7:0] rb;
        logic rs;

        tick(3);
        check("reset srx", {31'd0, srx}, 32'd1);
        check("reset signal", {31'd0, sig}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset valid", {31'd0, valid}, 32'd0);
        check("reset frame_err", {31'd0, ferr}, 32'd0);
        check("reset overrun", {31'd0, ovr}, 32'd0);
        rst = 1'b0;
        tick(3);

        // Single byte with strobe timing
        strobes.delete();
        vrise.delete();
        frame(8'hA5, 1'b1, 1'b0, p);
        check("strobe count", strobes.size(), 32'd10);
        for (int i = 0; i < 10; i++)
            if (i < strobes.size()) check("strobe time", strobes[i] - p, 10 + CPB * i);
        check("valid rise count", vrise.size(), 32'd1);
        if (vrise.size() > 0) check("valid rise time", vrise[0] - p, 11 + CPB * 9);
        check("single valid", {31'd0, valid}, 32'd1);
        check("single data", {24'd0, data}, 32'hA5);
        check("single frame_err", {31'd0, ferr}, 32'd0);
        check("single overrun", {31'd0, ovr}, 32'd0);
        ready = 1'b1;
        tick(3);
        ready = 1'b0;
        check("single drained", {31'd0, valid}, 32'd0);

        // Glitch on the line
        strobes.delete();
        n0 = rxv_cnt;
        p = cyc;
        rx_pin = 1'b0;
        tick(3);
        rx_pin = 1'b1;
        tick(20);
        check("glitch strobe count", strobes.size(), 32'd1);
        if (strobes.size() > 0) check("glitch strobe time", strobes[0] - p, 32'd10);
        check("glitch busy", {31'd0, busy}, 32'd0);
        check("glitch valid", {31'd0, valid}, 32'd0);
        check("glitch rx_valid", rxv_cnt - n0, 32'd0);

        // Framing error, then a good frame
        frame(8'h3C, 1'b0, 1'b0, p);
        tick(2);
        check("ferr set", {31'd0, ferr}, {31'd0, exp_ferr});
        check("ferr fifo empty", {31'd0, valid}, 32'd0);
        clear_err();
        check("ferr cleared", {31'd0, ferr}, 32'd0);
        frame(8'h3C, 1'b1, 1'b0, p);
        tick(2);
        check("after ferr valid", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        tick(2);
        ready = 1'b0;

        // Overrun: five bytes into four entries
        for (int b = 1; b <= 5; b++) frame(8'(b), 1'b1, 1'b0, p);
        tick(2);
        check("overrun flag", {31'd0, ovr}, {31'd0, exp_ovr});
        check("overrun head", {24'd0, data}, 32'h01);
        clear_err();
        check("overrun cleared", {31'd0, ovr}, 32'd0);

        // Full FIFO with pop coincident with the stop strobe
        frame(8'h77, 1'b1, 1'b1, p);
        wait_cnt = 0;
        while (valid && wait_cnt < 40) begin
            tick(1);
            wait_cnt++;
        end
        check("drain finished", {31'd0, valid}, 32'd0);
        check("full push/pop overrun", {31'd0, ovr}, 32'd0);
        check("scoreboard empty", exp_q.size(), 32'd0);
        ready = 1'b0;

        // Reset in the middle of a frame
        frame(8'h11, 1'b1, 1'b0, p);
        tick(2);
        check("pre-reset valid", {31'd0, valid}, 32'd1);
        strobes.delete();
        send(8'hC3, 1'b1, 4, 1'b0, p);
        check("pre-reset strobes", strobes.size(), 32'd5);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid reset busy", {31'd0, busy}, 32'd0);
        check("mid reset valid", {31'd0, valid}, 32'd0);
        check("mid reset srx", {31'd0, srx}, 32'd1);
        check("mid reset signal", {31'd0, sig}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);
        ready = 1'b1;
        frame(8'h5A, 1'b1, 1'b0, p);
        tick(3);
        check("post reset delivered", exp_q.size(), 32'd0);

        // Randomized frames with a free-running consumer
        clear_err();
        for (int k = 0; k < 12; k++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            frame(rb, rs, 1'b0, p);
            tick($urandom_range(2, 20));
        end
        tick(3);
        check("random frame_err", {31'd0, ferr}, {31'd0, exp_ferr});
        check("random overrun", {31'd0, ovr}, 32'd0);
        check("random all delivered", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
